// File: rtl/ibex_data_bus_arbiter.sv
// Two-host round-robin arbiter onto a single data bus with in-order response routing.
// A request left ungranted is locked until the device grants it.
module ibex_data_bus_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned DataWidth      = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [1:0]             host_req_i,
    output logic [1:0]             host_gnt_o,
    input  logic [63:0]            host_addr_i,
    input  logic [1:0]             host_we_i,
    input  logic [7:0]             host_be_i,
    input  logic [2*DataWidth-1:0] host_wdata_i,
    output logic [1:0]             host_rvalid_o,
    output logic [1:0]             host_err_o,
    output logic [DataWidth-1:0]   host_rdata_o,
    output logic                   data_req_o,
    input  logic                   data_gnt_i,
    output logic [31:0]            data_addr_o,
    output logic                   data_we_o,
    output logic [3:0]             data_be_o,
    output logic [DataWidth-1:0]   data_wdata_o,
    input  logic                   data_rvalid_i,
    input  logic                   data_err_i,
    input  logic [DataWidth-1:0]   data_rdata_i,
    output logic                   busy_o
);

    localparam int unsigned CntW = 3;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    arb_state_e                state_q, state_d;
    logic                      sel_q, sel_d;
    logic                      prio_q, prio_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [MaxOutstanding-1:0] ids_q, ids_d;

    logic            sel, sel_valid, full, grant, pop;
    logic [CntW-1:0] push_idx;

    assign full = (cnt_q == CntW'(MaxOutstanding));

    always_comb begin
        sel       = 1'b0;
        sel_valid = 1'b0;
        if (state_q == ARB_LOCKED) begin
            sel       = sel_q;
            sel_valid = !full;
        end else if (!full) begin
            unique case (host_req_i)
                2'b01:   begin sel = 1'b0;   sel_valid = 1'b1; end
                2'b10:   begin sel = 1'b1;   sel_valid = 1'b1; end
                2'b11:   begin sel = prio_q; sel_valid = 1'b1; end
                default: begin sel = 1'b0;   sel_valid = 1'b0; end
            endcase
        end
    end

    always_comb begin
        data_addr_o  = '0;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_wdata_o = '0;
        if (sel_valid) begin
            if (sel) begin
                data_addr_o  = host_addr_i[63:32];
                data_we_o    = host_we_i[1];
                data_be_o    = host_be_i[7:4];
                data_wdata_o = host_wdata_i[2*DataWidth-1:DataWidth];
            end else begin
                data_addr_o  = host_addr_i[31:0];
                data_we_o    = host_we_i[0];
                data_be_o    = host_be_i[3:0];
                data_wdata_o = host_wdata_i[DataWidth-1:0];
            end
        end
    end

    assign data_req_o   = sel_valid;
    assign grant        = sel_valid & data_gnt_i;
    // A response with nothing outstanding is spurious and never reaches a host.
    assign pop          = data_rvalid_i & (cnt_q != '0);
    assign host_rdata_o = data_rdata_i;
    assign busy_o       = (state_q == ARB_LOCKED) | (cnt_q != '0);

    always_comb begin
        host_gnt_o           = '0;
        host_gnt_o[sel]      = grant;
        host_rvalid_o        = '0;
        host_err_o           = '0;
        host_rvalid_o[ids_q[0]] = pop;
        host_err_o[ids_q[0]]    = pop & data_err_i;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (sel_valid && !data_gnt_i) begin
                    state_d = ARB_LOCKED;
                    sel_d   = sel;
                end
            end
            ARB_LOCKED: begin
                if (data_gnt_i) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
        if (grant) prio_d = ~sel;
    end

    // ID FIFO as a shift register with the head at index 0; a simultaneous
    // pop shifts first so the push lands one slot lower.
    always_comb begin
        ids_d    = ids_q;
        push_idx = cnt_q - CntW'(pop);
        if (pop) ids_d = ids_q >> 1;
        if (grant) begin
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                if (CntW'(i) == push_idx) ids_d[i] = sel;
            end
        end
        cnt_d = cnt_q + CntW'(grant) - CntW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            sel_q   <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            ids_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            ids_q   <= ids_d;
        end
    end

endmodule

// File: tb/tb_ibex_data_bus_arbiter.sv
// Directed bench for ibex_data_bus_arbiter: inputs change on the falling edge,
// outputs are checked 1ns later, state advances on the rising edge.
module tb_ibex_data_bus_arbiter;

    localparam int unsigned DW = 32;
    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;
    localparam logic [31:0] W0 = 32'hAAAA_0000;
    localparam logic [31:0] W1 = 32'hBBBB_1111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    host_req;
    logic [1:0]    host_gnt;
    logic [63:0]   host_addr;
    logic [1:0]    host_we;
    logic [7:0]    host_be;
    logic [2*DW-1:0] host_wdata;
    logic [1:0]    host_rvalid;
    logic [1:0]    host_err;
    logic [DW-1:0] host_rdata;
    logic          data_req;
    logic          data_gnt;
    logic [31:0]   data_addr;
    logic          data_we;
    logic [3:0]    data_be;
    logic [DW-1:0] data_wdata;
    logic          data_rvalid;
    logic          data_err;
    logic [DW-1:0] data_rdata;
    logic          busy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    ibex_data_bus_arbiter #(.MaxOutstanding(2), .DataWidth(DW)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .host_req_i    (host_req),
        .host_gnt_o    (host_gnt),
        .host_addr_i   (host_addr),
        .host_we_i     (host_we),
        .host_be_i     (host_be),
        .host_wdata_i  (host_wdata),
        .host_rvalid_o (host_rvalid),
        .host_err_o    (host_err),
        .host_rdata_o  (host_rdata),
        .data_req_o    (data_req),
        .data_gnt_i    (data_gnt),
        .data_addr_o   (data_addr),
        .data_we_o     (data_we),
        .data_be_o     (data_be),
        .data_wdata_o  (data_wdata),
        .data_rvalid_i (data_rvalid),
        .data_err_i    (data_err),
        .data_rdata_i  (data_rdata),
        .busy_o        (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step(input logic rst, input logic [1:0] req, input logic gnt,
                        input logic rv, input logic err, input logic [DW-1:0] rd);
        @(negedge clk);
        rst_n       = rst;
        host_req    = req;
        data_gnt    = gnt;
        data_rvalid = rv;
        data_err    = err;
        data_rdata  = rd;
        #1;
    endtask

    initial begin
        host_addr  = {A1, A0};
        host_we    = 2'b01;
        host_be    = 8'h3F;
        host_wdata = {W1, W0};

        // Reset
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_gnt", host_gnt, 0);
        check_eq("rst_rvalid", host_rvalid, 0);
        check_eq("rst_req", data_req, 0);
        check_eq("rst_addr", data_addr, 0);

        // Both hosts request, immediate grants: 0,1,0 with in-order responses
        step(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, '0);
        check_eq("rr1_req", data_req, 1);
        check_eq("rr1_gnt", host_gnt, 2'b01);
        check_eq("rr1_addr", data_addr, A0);
        check_eq("rr1_we", data_we, 1);
        check_eq("rr1_be", data_be, 4'hF);
        check_eq("rr1_wdata", data_wdata, W0);
        step(1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 32'h11);
        check_eq("rr2_gnt", host_gnt, 2'b10);
        check_eq("rr2_addr", data_addr, A1);
        check_eq("rr2_be", data_be, 4'h3);
        check_eq("rr2_wdata", data_wdata, W1);
        check_eq("rr2_rvalid", host_rvalid, 2'b01);
        check_eq("rr2_rdata", host_rdata, 32'h11);
        step(1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 32'h22);
        check_eq("rr3_gnt", host_gnt, 2'b01);
        check_eq("rr3_rvalid", host_rvalid, 2'b10);
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h33);
        check_eq("rr4_rvalid", host_rvalid, 2'b01);
        check_eq("rr4_req", data_req, 0);
        check_eq("rr4_busy", busy, 1);
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, '0);
        check_eq("rr5_busy", busy, 0);

        // Locked request: host 0 held for 3 ungranted cycles while host 1 joins
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, '0);
        check_eq("lk1_addr", data_addr, A0);
        check_eq("lk1_gnt", host_gnt, 0);
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, '0);
        check_eq("lk2_addr", data_addr, A0);
        check_eq("lk2_busy", busy, 1);
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, '0);
        check_eq("lk3_addr", data_addr, A0);
        check_eq("lk3_req", data_req, 1);
        step(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, '0);
        check_eq("lk4_gnt", host_gnt, 2'b01);
        check_eq("lk4_addr", data_addr, A0);
        step(1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 32'h44);
        check_eq("lk5_gnt", host_gnt, 2'b10);
        check_eq("lk5_rvalid", host_rvalid, 2'b01);
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h55);
        check_eq("lk6_rvalid", host_rvalid, 2'b10);

        // Outstanding limit of 2
        step(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, '0);
        check_eq("full1_gnt", host_gnt, 2'b01);
        step(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, '0);
        check_eq("full2_gnt", host_gnt, 2'b10);
        step(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, '0);
        check_eq("full3_req", data_req, 0);
        check_eq("full3_gnt", host_gnt, 0);
        check_eq("full3_addr", data_addr, 0);
        step(1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 32'h66);
        check_eq("full4_rvalid", host_rvalid, 2'b01);
        check_eq("full4_err", host_err, 2'b01);
        step(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, '0);
        check_eq("full5_req", data_req, 1);
        check_eq("full5_gnt", host_gnt, 2'b01);
        // now outstanding: host 1, host 0
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, '0);
        check_eq("full6_rvalid", host_rvalid, 2'b10);
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, '0);
        check_eq("full7_rvalid", host_rvalid, 2'b01);
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, '0);
        check_eq("full8_busy", busy, 0);

        // Grant to host 1 together with an erroring response for host 0
        step(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, '0);
        check_eq("pp1_gnt", host_gnt, 2'b01);
        step(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 32'h77);
        check_eq("pp2_gnt", host_gnt, 2'b10);
        check_eq("pp2_rvalid", host_rvalid, 2'b01);
        check_eq("pp2_err", host_err, 2'b01);
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h88);
        check_eq("pp3_rvalid", host_rvalid, 2'b10);
        check_eq("pp3_err", host_err, 2'b00);
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, '0);
        check_eq("pp4_busy", busy, 0);

        // Reset with two outstanding, then a late response
        step(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
        check_eq("mr_busy_pre", busy, 1);
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 32'h99);
        check_eq("mr_rvalid", host_rvalid, 2'b00);
        check_eq("mr_err", host_err, 2'b00);
        check_eq("mr_busy", busy, 0);

        // Spurious response while idle, then a normal transaction
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, '0);
        check_eq("sp_rvalid", host_rvalid, 2'b00);
        step(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, '0);
        check_eq("sp_busy", busy, 0);
        check_eq("sp_gnt", host_gnt, 2'b01);
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, '0);
        check_eq("sp_rvalid2", host_rvalid, 2'b01);
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, '0);
        check_eq("sp_busy2", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
